// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// store byte patterns and the size-to-byte-mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [3:0] ST_B = 4'b0001;
  localparam logic [3:0] ST_H = 4'b0011;
  localparam logic [3:0] ST_W = 4'b1111;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input logic [3:0] pat);
    case (pat)
      ST_W:    return SIZE_W;
      ST_H:    return SIZE_H;
      default: return SIZE_B;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and sign- or
// zero-extends byte and half loads to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = bus_rdata_i >> {off_i, 3'b000};
    case (size_i)
      SIZE_B:  data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one word-aligned data-bus transaction per accepted command.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of
// forcing them to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic [3:0]  mem_write,
  input  logic [1:0]  read_size,
  input  logic        read_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, addr_q, wdata_q;
  logic        we_q, sgn_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] load_data;

  logic        illegal, noop, trap, accept;
  logic [1:0]  acc_size, off_eff;

  // Command decode, evaluated on the raw inputs while IDLE.
  always_comb begin
    illegal  = (mem_read && (mem_write != 4'b0000)) || (read_size == 2'd3) ||
               !(mem_write inside {4'b0000, ST_B, ST_H, ST_W});
    noop     = !mem_read && (mem_write == 4'b0000);
    acc_size = mem_read ? read_size : store_size(mem_write);
`ifdef LSU_MISALIGN_TRAP_EN
    trap     = ((acc_size == SIZE_H) && addr[0]) ||
               ((acc_size == SIZE_W) && (addr[1:0] != 2'b00));
    off_eff  = addr[1:0];
`else
    trap     = 1'b0;
    case (acc_size)
      SIZE_H:  off_eff = {addr[1], 1'b0};
      SIZE_W:  off_eff = 2'b00;
      default: off_eff = addr[1:0];
    endcase
`endif
    accept   = (state_q == IDLE) && start && !illegal && !trap && !noop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Ack wins over timeout when both land in the last allowed cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          err_d = 1'b0;
          if (illegal || trap) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (noop) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    bus_req = (state_q == ACCESS);
    err     = err_q && (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      size_q  <= SIZE_B;
      off_q   <= 2'b00;
      sgn_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= {addr[31:2], 2'b00};
        we_q    <= !mem_read;
        be_q    <= mem_read ? (size_mask(read_size) << off_eff) : (mem_write << off_eff);
        wdata_q <= wdata << {off_eff, 3'b000};
        size_q  <= acc_size;
        off_q   <= off_eff;
        sgn_q   <= read_signed;
      end
      if ((state_q == ACCESS) && bus_ack && !we_q) begin
        rdata_q <= load_data;
      end
    end
  end

  lsu_load_align u_align (
    .bus_rdata_i (bus_rdata),
    .off_i       (off_q),
    .size_i      (size_q),
    .signed_i    (sgn_q),
    .data_o      (load_data)
  );

  assign rdata     = rdata_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYC=4). Inputs and checks happen
// on the falling edge; "cycle c" is the c-th falling edge after start is driven.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic [3:0]  mem_write = 4'b0000;
  logic [1:0]  read_size = 2'd0;
  logic        read_signed = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .read_size(read_size), .read_signed(read_signed),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  task automatic cmd(input logic rd, input logic [3:0] wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; read_size = sz; read_signed = sg;
    addr = a; wdata = wd; start = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({busy, done, err, bus_req, bus_we, bus_be} !== 9'd0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0", {busy, done, err, bus_req, bus_we, bus_be});
    end
    tests++;
    if ({rdata, bus_addr, bus_wdata} !== 96'd0) begin
      fails++; $display("FAIL reset_data got %h %h %h exp 0", rdata, bus_addr, bus_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] la[4]  = '{32'h1003, 32'h2002, 32'h0002, 32'h0001};
    logic [1:0]  lsz[4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    logic        lsg[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] lrd[4] = '{32'h80FF_FFFF, 32'hBEEF_1234, 32'h8001_5555, 32'h0000_F000};
    logic [31:0] lba[4] = '{32'h1000, 32'h2000, 32'h0000, 32'h0000};
    logic [3:0]  lbe[4] = '{4'b1000, 4'b1100, 4'b1100, 4'b0010};
    logic [31:0] lex[4] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00F0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd(1'b1, 4'b0000, lsz[i], lsg[i], la[i], 32'h0);
      bus_rdata = lrd[i];
      @(negedge clk);
      start = 1'b0; bus_ack = 1'b1;
      tests++;
      if ({busy, done, bus_req, bus_we, bus_be, bus_addr} !== {4'b1010, lbe[i], lba[i]}) begin
        fails++; $display("FAIL load%0d_bus got %b %b %h exp %b %h", i,
                          {busy, done, bus_req, bus_we}, bus_be, bus_addr, lbe[i], lba[i]);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      tests++;
      if ({busy, done, err, bus_req, rdata} !== {4'b1100, lex[i]}) begin
        fails++; $display("FAIL load%0d_done got %b %h exp 1100 %h", i,
                          {busy, done, err, bus_req}, rdata, lex[i]);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL load%0d_idle got busy=%b exp 0", i, busy);
      end
    end
  endtask

  task automatic test_store_delayed();
    @(negedge clk);
    cmd(1'b0, 4'b0001, 2'd0, 1'b0, 32'h11, 32'hAB);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus_ack = (c == 4);
      tests++;
      if ({busy, done, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !==
          {4'b1011, 4'b0010, 32'h10, 32'h0000_AB00}) begin
        fails++; $display("FAIL sb_cycle%0d got %b %b %h %h exp 1011 0010 10 ab00", c,
                          {busy, done, bus_req, bus_we}, bus_be, bus_addr, bus_wdata);
      end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    tests++;
    if ({done, err, bus_req, rdata} !== {3'b100, 32'h0000_00F0}) begin
      fails++; $display("FAIL sb_done got %b %h exp 100 000000f0", {done, err, bus_req}, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    cmd(1'b1, 4'b0000, 2'd2, 1'b0, 32'h6, 32'h0);
    bus_rdata = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    tests++;
    if ({busy, done, err, bus_req} !== 4'b1110) begin
      fails++; $display("FAIL lw_trap got %b exp 1110", {busy, done, err, bus_req});
    end
`else
    bus_ack = 1'b1;
    tests++;
    if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h4, 4'b1111}) begin
      fails++; $display("FAIL lw_align got %b %h %b exp 1 4 1111", bus_req, bus_addr, bus_be);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    tests++;
    if ({done, err, rdata} !== {2'b10, 32'h1234_5678}) begin
      fails++; $display("FAIL lw_align_done got %b %h exp 10 12345678", {done, err}, rdata);
    end
`endif
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL lw_misalign_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_timeout();
`ifdef LSU_MISALIGN_TRAP_EN
    logic [31:0] prev = 32'h0000_00F0;
`else
    logic [31:0] prev = 32'h1234_5678;
`endif
    @(negedge clk);
    cmd(1'b1, 4'b0000, 2'd2, 1'b0, 32'h8, 32'h0);
    bus_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({busy, done, bus_req} !== 3'b101) begin
        fails++; $display("FAIL to_cycle%0d got %b exp 101", c, {busy, done, bus_req});
      end
    end
    @(negedge clk);
    tests++;
    if ({done, err, bus_req, rdata} !== {3'b110, prev}) begin
      fails++; $display("FAIL to_done got %b %h exp 110 %h", {done, err, bus_req}, rdata, prev);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_at_limit();
    @(negedge clk);
    cmd(1'b1, 4'b0000, 2'd2, 1'b0, 32'hC, 32'h0);
    bus_rdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus_ack = (c == 4);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    tests++;
    if ({done, err, rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      fails++; $display("FAIL ack_limit got %b %h exp 10 cafef00d", {done, err}, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_noop();
    logic [3:0] iw[4] = '{4'b0001, 4'b0000, 4'b0111, 4'b0000};
    logic       ir[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] isz[4] = '{2'd2, 2'd3, 2'd0, 2'd0};
    logic       ie[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd(ir[i], iw[i], isz[i], 1'b0, 32'h40, 32'h55);
      bus_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({busy, done, err, bus_req} !== {2'b11, ie[i], 1'b0}) begin
        fails++; $display("FAIL illegal%0d got %b exp 11%b0", i, {busy, done, err, bus_req}, ie[i]);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      tests++;
      if ({busy, rdata} !== {1'b0, 32'hCAFE_F00D}) begin
        fails++; $display("FAIL illegal%0d_after got %b %h exp 0 cafef00d", i, busy, rdata);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    @(negedge clk);
    cmd(1'b1, 4'b0000, 2'd2, 1'b0, 32'h20, 32'h0);
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    tests++;
    if ({busy, done, bus_req, rdata} !== {3'b110, 32'h1111_2222}) begin
      fails++; $display("FAIL b2b_done got %b %h exp 110 11112222", {busy, done, bus_req}, rdata);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL b2b_idle got busy=%b exp 0", busy);
    end
    @(negedge clk);
    tests++;
    if ({busy, bus_req, bus_addr} !== {2'b11, 32'h20}) begin
      fails++; $display("FAIL b2b_second got %b %h exp 11 20", {busy, bus_req}, bus_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, bus_req, rdata} !== {3'b000, 32'h0}) begin
      fails++; $display("FAIL midreset got %b %h exp 000 0", {busy, done, bus_req}, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL post_reset got %b exp 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_delayed();
    test_misalign();
    test_timeout();
    test_ack_at_limit();
    test_illegal_noop();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
